// File: rtl/pipe_pkg.sv
// Shared pipeline constants: NOOP control word, control-bit indices, ALU op codes.
package pipe_pkg;

    localparam logic [15:0] NOOP_MUXCTRL = 16'h0000;
    localparam logic [2:0]  NOOP_MEMCTRL = 3'b000;
    localparam logic [4:0]  NOOP_ALUCTRL = 5'b01101;

    localparam int MEM_REGWR = 0;
    localparam int MEM_WR    = 1;
    localparam int MEM_RD    = 2;

    localparam int IMM_SRC0   = 0;
    localparam int IMM_SRC1   = 1;
    localparam int ALU_SRC    = 2;
    localparam int REG_DST0   = 3;
    localparam int REG_DST1   = 4;
    localparam int MEM_TO_REG = 5;
    localparam int SHIFT_SRC  = 6;
    localparam int JUMP       = 7;
    localparam int JAL        = 8;
    localparam int JR         = 9;
    localparam int BRANCH     = 10;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_XOR = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRL = 5'b00101;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOP = NOOP_ALUCTRL;

    typedef struct packed {
        logic [15:0] muxctrl;
        logic [2:0]  memctrl;
        logic [4:0]  aluctrl;
    } ctrl_t;

    localparam ctrl_t NOOP_CTRL = '{muxctrl: NOOP_MUXCTRL, memctrl: NOOP_MEMCTRL, aluctrl: NOOP_ALUCTRL};

    // A load is the only producer whose result is late enough to need a bubble.
    function automatic logic is_load(input logic [2:0] memctrl);
        return memctrl[MEM_RD] & memctrl[MEM_REGWR];
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: ID-side operands/controls in, EX register and stall out.
interface id_ex_stage_if #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 16
);
    logic            id_valid;
    logic [15:0]     id_muxctrl;
    logic [2:0]      id_memctrl;
    logic [4:0]      id_aluctrl;
    logic [RW-1:0]   id_rs, id_rt, id_dest;
    logic            id_uses_rs, id_uses_rt;
    logic [DW-1:0]   id_rdata1, id_rdata2, id_imm, id_pc;
    logic [4:0]      id_shamt;
    logic            flush, hold;

    logic            stall;
    logic            ex_valid;
    logic [15:0]     ex_muxctrl;
    logic [2:0]      ex_memctrl;
    logic [4:0]      ex_aluctrl;
    logic [RW-1:0]   ex_rs, ex_rt, ex_dest;
    logic [DW-1:0]   ex_rdata1, ex_rdata2, ex_imm, ex_pc;
    logic [4:0]      ex_shamt;
    logic [CNTW-1:0] bubble_count, stall_count;

    modport master (
        output id_valid, id_muxctrl, id_memctrl, id_aluctrl, id_rs, id_rt, id_dest,
               id_uses_rs, id_uses_rt, id_rdata1, id_rdata2, id_imm, id_pc, id_shamt,
               flush, hold,
        input  stall, ex_valid, ex_muxctrl, ex_memctrl, ex_aluctrl, ex_rs, ex_rt, ex_dest,
               ex_rdata1, ex_rdata2, ex_imm, ex_pc, ex_shamt, bubble_count, stall_count
    );

    modport slave (
        input  id_valid, id_muxctrl, id_memctrl, id_aluctrl, id_rs, id_rt, id_dest,
               id_uses_rs, id_uses_rt, id_rdata1, id_rdata2, id_imm, id_pc, id_shamt,
               flush, hold,
        output stall, ex_valid, ex_muxctrl, ex_memctrl, ex_aluctrl, ex_rs, ex_rt, ex_dest,
               ex_rdata1, ex_rdata2, ex_imm, ex_pc, ex_shamt, bubble_count, stall_count
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard check of the ID instruction against the load sitting in EX.
module hazard_detect #(
    parameter int RW = 5
) (
    input  logic          ex_valid_i,
    input  logic          ex_load_i,
    input  logic [RW-1:0] ex_dest_i,
    input  logic          id_valid_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    input  logic          id_uses_rs_i,
    input  logic          id_uses_rt_i,
    output logic          hazard_o
);
    logic rs_match, rt_match;

    assign rs_match = id_uses_rs_i && (ex_dest_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (ex_dest_i == id_rt_i);

    // r0 is hardwired zero, so a load targeting it never produces a value.
    assign hazard_o = ex_valid_i && ex_load_i && (ex_dest_i != '0) && id_valid_i
                      && (rs_match || rt_match);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold and perf counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 16
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    logic            hazard, stall;
    logic            bub_inc;

    ctrl_t           ctrl_q, ctrl_d;
    logic            valid_q, valid_d;
    logic [RW-1:0]   rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    logic [DW-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
    logic [4:0]      shamt_q, shamt_d;
    logic [CNTW-1:0] bub_q, bub_d, stl_q, stl_d;

    hazard_detect #(.RW(RW)) u_hazard (
        .ex_valid_i   (valid_q),
        .ex_load_i    (is_load(ctrl_q.memctrl)),
        .ex_dest_i    (dest_q),
        .id_valid_i   (bus.id_valid),
        .id_rs_i      (bus.id_rs),
        .id_rt_i      (bus.id_rt),
        .id_uses_rs_i (bus.id_uses_rs),
        .id_uses_rt_i (bus.id_uses_rt),
        .hazard_o     (hazard)
    );

    // A flush squashes the consumer, so the hazard it would have raised is moot.
    assign stall = bus.hold | (hazard & ~bus.flush);

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        dest_d  = dest_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        shamt_d = shamt_q;
        bub_inc = 1'b0;
        if (!bus.hold) begin
            if (bus.flush || hazard) begin
                ctrl_d  = NOOP_CTRL;
                valid_d = 1'b0;
                rs_d    = '0;
                rt_d    = '0;
                dest_d  = '0;
                rd1_d   = '0;
                rd2_d   = '0;
                imm_d   = '0;
                pc_d    = '0;
                shamt_d = '0;
                bub_inc = bus.flush ? bus.id_valid : 1'b1;
            end else begin
                ctrl_d  = bus.id_valid ? ctrl_t'{bus.id_muxctrl, bus.id_memctrl, bus.id_aluctrl}
                                       : NOOP_CTRL;
                valid_d = bus.id_valid;
                rs_d    = bus.id_rs;
                rt_d    = bus.id_rt;
                dest_d  = bus.id_dest;
                rd1_d   = bus.id_rdata1;
                rd2_d   = bus.id_rdata2;
                imm_d   = bus.id_imm;
                pc_d    = bus.id_pc;
                shamt_d = bus.id_shamt;
            end
        end
        bub_d = (bub_inc && (bub_q != '1)) ? bub_q + 1'b1 : bub_q;
        stl_d = (stall && (stl_q != '1)) ? stl_q + 1'b1 : stl_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= NOOP_CTRL;
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            dest_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            shamt_q <= '0;
            bub_q   <= '0;
            stl_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            dest_q  <= dest_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            shamt_q <= shamt_d;
            bub_q   <= bub_d;
            stl_q   <= stl_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.ex_valid     = valid_q;
    assign bus.ex_muxctrl   = ctrl_q.muxctrl;
    assign bus.ex_memctrl   = ctrl_q.memctrl;
    assign bus.ex_aluctrl   = ctrl_q.aluctrl;
    assign bus.ex_rs        = rs_q;
    assign bus.ex_rt        = rt_q;
    assign bus.ex_dest      = dest_q;
    assign bus.ex_rdata1    = rd1_q;
    assign bus.ex_rdata2    = rd2_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_pc        = pc_q;
    assign bus.ex_shamt     = shamt_q;
    assign bus.bubble_count = bub_q;
    assign bus.stall_count  = stl_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized run against a cycle model.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int CNTW = 16;
    localparam int MAXC = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic reset;
    int   cmp_n = 0;
    int   err_n = 0;

    id_ex_stage_if #(.DW(DW), .RW(RW), .CNTW(CNTW)) bus ();
    id_ex_stage #(.DW(DW), .RW(RW), .CNTW(CNTW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Expected EX register contents and counters.
    logic          m_valid;
    logic [15:0]   m_mux;
    logic [2:0]    m_mem;
    logic [4:0]    m_alu, m_sh;
    logic [RW-1:0] m_rs, m_rt, m_dest;
    logic [DW-1:0] m_r1, m_r2, m_imm, m_pc;
    int            m_bub, m_stl;

    function automatic logic model_hazard();
        if (!(m_valid && m_mem == 3'b101 || m_valid && m_mem[2] && m_mem[0])) return 1'b0;
        if (m_dest == 0 || !bus.id_valid) return 1'b0;
        return (bus.id_uses_rs && m_dest == bus.id_rs) || (bus.id_uses_rt && m_dest == bus.id_rt);
    endfunction

    function automatic logic model_stall();
        return bus.hold || (model_hazard() && !bus.flush);
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_mux = 16'h0000; m_mem = 3'b000; m_alu = 5'b01101;
        m_rs = 0; m_rt = 0; m_dest = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_pc = 0; m_sh = 0;
    endtask

    task automatic model_edge();
        logic st, hz;
        st = model_stall();
        hz = model_hazard();
        if (reset) begin
            model_bubble();
            m_bub = 0;
            m_stl = 0;
        end else begin
            if (st) m_stl = (m_stl == MAXC) ? MAXC : m_stl + 1;
            if (bus.hold) begin
            end else if (bus.flush || hz) begin
                if (!bus.flush || bus.id_valid) m_bub = (m_bub == MAXC) ? MAXC : m_bub + 1;
                model_bubble();
            end else begin
                m_valid = bus.id_valid;
                m_mux = bus.id_valid ? bus.id_muxctrl : 16'h0000;
                m_mem = bus.id_valid ? bus.id_memctrl : 3'b000;
                m_alu = bus.id_valid ? bus.id_aluctrl : 5'b01101;
                m_rs = bus.id_rs; m_rt = bus.id_rt; m_dest = bus.id_dest;
                m_r1 = bus.id_rdata1; m_r2 = bus.id_rdata2; m_imm = bus.id_imm;
                m_pc = bus.id_pc; m_sh = bus.id_shamt;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [2:0] mem, input logic [4:0] alu,
                            input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                            input logic [RW-1:0] dest, input logic urs, input logic urt);
        bus.id_valid = v;   bus.id_memctrl = mem; bus.id_aluctrl = alu;
        bus.id_rs = rs;     bus.id_rt = rt;       bus.id_dest = dest;
        bus.id_uses_rs = urs; bus.id_uses_rt = urt;
        bus.id_muxctrl = 16'($urandom);
        bus.id_rdata1 = $urandom; bus.id_rdata2 = $urandom;
        bus.id_imm = $urandom;    bus.id_pc = $urandom;
        bus.id_shamt = 5'($urandom);
    endtask

    task automatic test_reset();
        bus.hold = 0; bus.flush = 0;
        drive_id(1, 3'b101, ALU_ADD, 5'd3, 5'd4, 5'd7, 1, 1);
        reset = 1;
        tick(); tick();
        cmp_n++; if (bus.ex_aluctrl !== 5'b01101) begin err_n++; $display("FAIL reset_alu got %b exp 01101", bus.ex_aluctrl); end
        cmp_n++; if (bus.ex_memctrl !== 3'b000) begin err_n++; $display("FAIL reset_mem got %b exp 000", bus.ex_memctrl); end
        cmp_n++; if (bus.ex_valid !== 1'b0) begin err_n++; $display("FAIL reset_valid got %b exp 0", bus.ex_valid); end
        cmp_n++; if (bus.bubble_count !== 16'd0 || bus.stall_count !== 16'd0) begin err_n++;
            $display("FAIL reset_counters got %0d/%0d exp 0/0", bus.bubble_count, bus.stall_count); end
        cmp_n++; if (bus.stall !== 1'b0) begin err_n++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
        reset = 0;
    endtask

    task automatic test_load_use();
        drive_id(1, 3'b101, ALU_ADD, 5'd1, 5'd2, 5'd8, 1, 0);
        #1; tick();
        drive_id(1, 3'b001, ALU_ADD, 5'd8, 5'd5, 5'd9, 1, 1);
        #1;
        cmp_n++; if (bus.stall !== 1'b1) begin err_n++; $display("FAIL lu_stall got %b exp 1", bus.stall); end
        tick();
        cmp_n++; if (bus.ex_valid !== 1'b0 || bus.ex_aluctrl !== 5'b01101 || bus.ex_memctrl !== 3'b000) begin err_n++;
            $display("FAIL lu_bubble got v=%b alu=%b mem=%b exp v=0 alu=01101 mem=000", bus.ex_valid, bus.ex_aluctrl, bus.ex_memctrl); end
        cmp_n++; if (bus.bubble_count !== 16'd1) begin err_n++; $display("FAIL lu_bubcnt got %0d exp 1", bus.bubble_count); end
        cmp_n++; if (bus.stall !== 1'b0) begin err_n++; $display("FAIL lu_stall_drop got %b exp 0", bus.stall); end
        tick();
        cmp_n++; if (bus.ex_valid !== 1'b1 || bus.ex_aluctrl !== 5'b00010 || bus.ex_rs !== 5'd8) begin err_n++;
            $display("FAIL lu_consumer got v=%b alu=%b rs=%0d exp v=1 alu=00010 rs=8", bus.ex_valid, bus.ex_aluctrl, bus.ex_rs); end
        cmp_n++; if (bus.stall_count !== 16'd1) begin err_n++; $display("FAIL lu_stlcnt got %0d exp 1", bus.stall_count); end
    endtask

    task automatic test_r0();
        drive_id(1, 3'b101, ALU_ADD, 5'd1, 5'd2, 5'd0, 1, 0);
        #1; tick();
        drive_id(1, 3'b001, ALU_SUB, 5'd0, 5'd0, 5'd6, 1, 1);
        #1;
        cmp_n++; if (bus.stall !== 1'b0) begin err_n++; $display("FAIL r0_stall got %b exp 0", bus.stall); end
        tick();
        cmp_n++; if (bus.ex_valid !== 1'b1 || bus.ex_aluctrl !== ALU_SUB) begin err_n++;
            $display("FAIL r0_load got v=%b alu=%b exp v=1 alu=%b", bus.ex_valid, bus.ex_aluctrl, ALU_SUB); end
    endtask

    task automatic test_hazard_flush();
        int b0;
        drive_id(1, 3'b101, ALU_ADD, 5'd1, 5'd2, 5'd8, 1, 0);
        #1; tick();
        b0 = m_bub;
        drive_id(1, 3'b001, ALU_ADD, 5'd3, 5'd8, 5'd9, 0, 1);
        bus.flush = 1;
        #1;
        cmp_n++; if (bus.stall !== 1'b0) begin err_n++; $display("FAIL hf_stall got %b exp 0", bus.stall); end
        tick();
        cmp_n++; if (bus.ex_valid !== 1'b0 || bus.ex_aluctrl !== 5'b01101 || bus.ex_memctrl !== 3'b000) begin err_n++;
            $display("FAIL hf_noop got v=%b alu=%b mem=%b exp v=0 alu=01101 mem=000", bus.ex_valid, bus.ex_aluctrl, bus.ex_memctrl); end
        cmp_n++; if (int'(bus.bubble_count) !== b0 + 1) begin err_n++; $display("FAIL hf_bubcnt got %0d exp %0d", bus.bubble_count, b0 + 1); end
        bus.flush = 0;
    endtask

    task automatic test_hold();
        int s0;
        drive_id(1, 3'b001, ALU_SUB, 5'd2, 5'd3, 5'd4, 1, 1);
        #1; tick();
        s0 = m_stl;
        drive_id(1, 3'b001, ALU_ADD, 5'd4, 5'd4, 5'd5, 1, 1);
        bus.hold = 1; bus.flush = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            cmp_n++; if (bus.stall !== 1'b1) begin err_n++; $display("FAIL hold_stall[%0d] got %b exp 1", i, bus.stall); end
            tick();
            cmp_n++; if (bus.ex_valid !== 1'b1 || bus.ex_aluctrl !== ALU_SUB || bus.ex_dest !== 5'd4) begin err_n++;
                $display("FAIL hold_frozen[%0d] got v=%b alu=%b dest=%0d exp v=1 alu=%b dest=4", i, bus.ex_valid, bus.ex_aluctrl, bus.ex_dest, ALU_SUB); end
        end
        cmp_n++; if (int'(bus.stall_count) !== s0 + 3) begin err_n++; $display("FAIL hold_stlcnt got %0d exp %0d", bus.stall_count, s0 + 3); end
        bus.hold = 0; bus.flush = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.hold = ($urandom_range(0, 99) < 8);
            bus.flush = ($urandom_range(0, 99) < 10);
            drive_id($urandom_range(0, 9) < 8,
                     $urandom_range(0, 1) ? 3'b101 : 3'($urandom),
                     5'($urandom),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom));
            #1;
            cmp_n++; if (bus.stall !== model_stall()) begin err_n++; $display("FAIL rnd_stall[%0d] got %b exp %b", i, bus.stall, model_stall()); end
            tick();
            cmp_n++; if ({bus.ex_valid, bus.ex_muxctrl, bus.ex_memctrl, bus.ex_aluctrl} !== {m_valid, m_mux, m_mem, m_alu}) begin err_n++;
                $display("FAIL rnd_ctrl[%0d] got %h exp %h", i, {bus.ex_valid, bus.ex_muxctrl, bus.ex_memctrl, bus.ex_aluctrl}, {m_valid, m_mux, m_mem, m_alu}); end
            if (m_valid) begin
                cmp_n++; if ({bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm, bus.ex_pc, bus.ex_shamt}
                             !== {m_rs, m_rt, m_dest, m_r1, m_r2, m_imm, m_pc, m_sh}) begin err_n++;
                    $display("FAIL rnd_data[%0d] got %h exp %h", i,
                             {bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm, bus.ex_pc, bus.ex_shamt},
                             {m_rs, m_rt, m_dest, m_r1, m_r2, m_imm, m_pc, m_sh}); end
            end
            cmp_n++; if (int'(bus.bubble_count) !== m_bub || int'(bus.stall_count) !== m_stl) begin err_n++;
                $display("FAIL rnd_counters[%0d] got %0d/%0d exp %0d/%0d", i, bus.bubble_count, bus.stall_count, m_bub, m_stl); end
        end
        reset = 0; bus.hold = 0; bus.flush = 0;
    endtask

    task automatic test_saturate();
        bus.hold = 1;
        repeat ((1 << CNTW) + 5) tick();
        cmp_n++; if (bus.stall_count !== 16'hFFFF) begin err_n++; $display("FAIL sat_stlcnt got %h exp ffff", bus.stall_count); end
        reset = 1;
        tick();
        cmp_n++; if (bus.stall_count !== 16'd0 || bus.bubble_count !== 16'd0 || bus.ex_valid !== 1'b0) begin err_n++;
            $display("FAIL reset_in_hold got stl=%0d bub=%0d v=%b exp 0/0/0", bus.stall_count, bus.bubble_count, bus.ex_valid); end
        reset = 0; bus.hold = 0;
    endtask

    initial begin
        reset = 1;
        model_bubble();
        m_bub = 0; m_stl = 0;
        test_reset();
        test_load_use();
        test_r0();
        test_hazard_flush();
        test_hold();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
